rom_load_arbiter: RTL and testbench
===================================

Name: rom_load_arbiter

Overview:
- Sits between the HPS ROM download stream (dn_addr/dn_data/dn_wr) and the single-port synchronous ROM RAM used by scramble_top.
- Sequences download, then a post-load reset hold, then normal run.
- Shares the one RAM port between download writes and CPU/video fetch reads, with writes taking priority.
- Generates the core reset, and reports load progress and overrun.

Parameters:
- HOLD_CYCLES, 1024, clk cycles core_reset stays high after download ends.
- ROM_TOP, 16'hBFFF, highest valid download address; writes above it are dropped and counted.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- dn_download  in  1  high while an HPS download is in progress.
- dn_wr  in  1  one-cycle write strobe, valid only while dn_download=1.
- dn_addr  in  16  download byte address.
- dn_data  in  8  download byte.
- rd_req  in  1  core read request, level; held until rd_ack.
- rd_addr  in  16  core read address, stable while rd_req=1.
- rd_data  out  8  read data, valid in the rd_ack cycle.
- rd_ack  out  1  one-cycle read completion.
- mem_addr  out  16  RAM address.
- mem_wdata  out  8  RAM write data.
- mem_we  out  1  RAM write enable.
- mem_rdata  in  8  RAM read data, 1-cycle latency after address.
- core_reset  out  1  reset to scramble_top.
- loaded  out  1  high once a download has completed and the hold has expired.
- dropped  out  8  saturating count of out-of-range or overrun writes.

Behaviour:
- FSM states: BOOT, LOAD, HOLD, RUN.
  - RESET → BOOT.
  - BOOT: dn_download=1 → LOAD.
  - LOAD: dn_download falls → HOLD, and the hold counter is loaded with HOLD_CYCLES-1.
  - HOLD: counter reaches 0 → RUN. dn_download=1 while in HOLD → LOAD.
  - RUN: dn_download=1 → LOAD.
- core_reset = 1 in BOOT, LOAD and HOLD; 0 only in RUN.
- loaded is set on the HOLD→RUN transition and cleared on entering LOAD.
- Reset values: core_reset=1, loaded=0, dropped=0, rd_ack=0, mem_we=0, mem_addr=0, mem_wdata=0, rd_data=0.
- Write path:
  - dn_wr with dn_addr ≤ ROM_TOP captures {addr,data} into a 1-entry pending register.
  - The pending write is issued as mem_we=1 on the next cycle in which the port is not completing a read. A read is completing when its address was issued last cycle and its data returns this cycle.
  - dn_wr with dn_addr > ROM_TOP does not write and increments dropped.
  - dn_wr while the pending register is still full is an overrun: the new byte is discarded and dropped increments.
  - dropped saturates at 255.
  - The pending register is still drained after dn_download falls, before HOLD counts down: the counter does not decrement while pending is full.
- Read path:
  - rd_req is served only when the port is free that cycle: no pending write and no read in flight.
  - Cycle N: mem_addr = rd_addr, mem_we = 0.
  - Cycle N+1: rd_data = mem_rdata, rd_ack = 1.
  - Minimum latency is 2 cycles from rd_req high to rd_ack.
  - At most one read in flight. rd_req still high in the ack cycle starts a new read on the next cycle.
- Priority: a pending write beats a new read in the same cycle. An in-flight read is never aborted; the write waits 1 cycle.
- Reads are honoured in every state. The core is in reset outside RUN, so reads there are legal but not expected.
- mem_we is high for exactly one cycle per accepted write. mem_addr/mem_wdata hold their last value when idle.
- RESET mid-operation:
  - The pending write is discarded.
  - An in-flight read completes no ack.
  - The FSM returns to BOOT and dropped clears.
- Simultaneous dn_wr and the drain of the pending entry in the same cycle: the entry is freed first, so the new byte is accepted with no overrun.

Test Plan:
- Reset, then dn_download=1 and 4 writes (addr 0..3, data A0..A3) spaced 3 cycles apart → 4 single-cycle mem_we pulses with matching addr/data; core_reset=1; dropped=0.
- dn_download falls with HOLD_CYCLES=16 → core_reset stays 1 for 16 cycles (plus any drain), then 0; loaded=1 in the same cycle.
- In RUN, rd_req with rd_addr=0x0002, mem_rdata returning A2 → mem_addr=0x0002 one cycle after the request, rd_ack=1 and rd_data=A2 one cycle later.
- Write to 0xC000 with ROM_TOP=0xBFFF → no mem_we; dropped=1.
- A read issued in cycle N while dn_wr arrives in cycle N, and a second dn_wr arrives in N+1 → the read acks at N+1, the first write issues at N+2, the second write counts as overrun; dropped increments by 1.
- Assert RESET during HOLD with a pending write → no mem_we follows; core_reset=1; loaded=0; state BOOT (no transition to RUN without a new download).

Source files
------------

// File: rtl/rom_load_arbiter.sv
// Arbitrates the single ROM RAM port between HPS download writes and core reads,
// sequences download -> reset hold -> run, and counts discarded download bytes.
module rom_load_arbiter #(
    parameter int unsigned HOLD_CYCLES = 1024,
    parameter logic [15:0] ROM_TOP     = 16'hBFFF
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        dn_download,
    input  logic        dn_wr,
    input  logic [15:0] dn_addr,
    input  logic [7:0]  dn_data,
    input  logic        rd_req,
    input  logic [15:0] rd_addr,
    output logic [7:0]  rd_data,
    output logic        rd_ack,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata,
    output logic        core_reset,
    output logic        loaded,
    output logic [7:0]  dropped
);

    localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {BOOT, LOAD, HOLD, RUN} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   hold_cnt, hold_cnt_next;
    logic               pend_valid, pend_valid_next;
    logic [15:0]        pend_addr, pend_addr_next;
    logic [7:0]         pend_data, pend_data_next;
    logic               rd_busy, rd_busy_next;
    logic               rd_ack_next;
    logic [15:0]        mem_addr_next;
    logic [7:0]         mem_wdata_next;
    logic               mem_we_next;
    logic               core_reset_next;
    logic               loaded_next;
    logic [7:0]         dropped_next;

    logic               wr_issue;
    logic               rd_issue;
    logic               drop_inc;

    // The RAM returns data only in the ack cycle, so read data is forwarded
    // straight through, masked to zero outside that cycle.
    assign rd_data = rd_ack ? mem_rdata : 8'h00;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (RESET) begin
            state      <= BOOT;
            hold_cnt   <= '0;
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            pend_data  <= '0;
            rd_busy    <= 1'b0;
            rd_ack     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            core_reset <= 1'b1;
            loaded     <= 1'b0;
            dropped    <= '0;
        end else begin
            state      <= state_next;
            hold_cnt   <= hold_cnt_next;
            pend_valid <= pend_valid_next;
            pend_addr  <= pend_addr_next;
            pend_data  <= pend_data_next;
            rd_busy    <= rd_busy_next;
            rd_ack     <= rd_ack_next;
            mem_addr   <= mem_addr_next;
            mem_wdata  <= mem_wdata_next;
            mem_we     <= mem_we_next;
            core_reset <= core_reset_next;
            loaded     <= loaded_next;
            dropped    <= dropped_next;
        end
    end

    // Port arbitration, download capture, sequencing FSM
    always_comb begin
        state_next      = state;
        hold_cnt_next   = hold_cnt;
        pend_valid_next = pend_valid;
        pend_addr_next  = pend_addr;
        pend_data_next  = pend_data;
        rd_busy_next    = 1'b0;
        rd_ack_next     = rd_busy;
        mem_addr_next   = mem_addr;
        mem_wdata_next  = mem_wdata;
        mem_we_next     = 1'b0;
        loaded_next     = loaded;
        dropped_next    = dropped;
        drop_inc        = 1'b0;

        // A read whose address is on the port now completes next cycle; the
        // write waits behind it rather than landing in the completion cycle.
        wr_issue = pend_valid && !rd_busy;
        rd_issue = rd_req && !pend_valid && !rd_busy;

        if (wr_issue) begin
            mem_addr_next   = pend_addr;
            mem_wdata_next  = pend_data;
            mem_we_next     = 1'b1;
            pend_valid_next = 1'b0;
        end else if (rd_issue) begin
            mem_addr_next = rd_addr;
            rd_busy_next  = 1'b1;
        end

        // A slot being drained this cycle is free for the incoming byte.
        if (dn_wr && dn_download) begin
            if ((dn_addr <= ROM_TOP) && (!pend_valid || wr_issue)) begin
                pend_valid_next = 1'b1;
                pend_addr_next  = dn_addr;
                pend_data_next  = dn_data;
            end else begin
                drop_inc = 1'b1;
            end
        end

        if (drop_inc && (dropped != 8'hFF)) begin
            dropped_next = dropped + 8'd1;
        end

        case (state)
            BOOT: begin
                if (dn_download) state_next = LOAD;
            end
            LOAD: begin
                if (!dn_download) begin
                    state_next    = HOLD;
                    hold_cnt_next = CNT_W'(HOLD_CYCLES - 1);
                end
            end
            HOLD: begin
                if (dn_download) begin
                    state_next = LOAD;
                end else if (!pend_valid) begin
                    if (hold_cnt == '0) state_next = RUN;
                    else                hold_cnt_next = hold_cnt - CNT_W'(1);
                end
            end
            RUN: begin
                if (dn_download) state_next = LOAD;
            end
            default: state_next = BOOT;
        endcase

        if ((state == HOLD) && (state_next == RUN)) loaded_next = 1'b1;
        if (state_next == LOAD)                     loaded_next = 1'b0;

        core_reset_next = (state_next != RUN);
    end

endmodule

// File: tb/tb_rom_load_arbiter.sv
// Directed bench for rom_load_arbiter: download, hold, reads, drops, overrun and
// mid-hold reset, against hand-computed cycle timing and a behavioural RAM.
module tb_rom_load_arbiter;

    localparam int unsigned HOLD = 16;

    logic        clk = 1'b0;
    logic        RESET;
    logic        dn_download;
    logic        dn_wr;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic        rd_req;
    logic [15:0] rd_addr;
    logic [7:0]  rd_data;
    logic        rd_ack;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic        core_reset;
    logic        loaded;
    logic [7:0]  dropped;

    logic [7:0]  ram [0:65535];
    logic [23:0] we_q [$];
    int          checks = 0;
    int          failures = 0;
    int          n;
    int          we_before;

    always #5 clk = ~clk;

    rom_load_arbiter #(.HOLD_CYCLES(HOLD), .ROM_TOP(16'hBFFF)) dut (
        .clk        (clk),
        .RESET      (RESET),
        .dn_download(dn_download),
        .dn_wr      (dn_wr),
        .dn_addr    (dn_addr),
        .dn_data    (dn_data),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_ack     (rd_ack),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata),
        .core_reset (core_reset),
        .loaded     (loaded),
        .dropped    (dropped)
    );

    // Single-port synchronous RAM, one-cycle read latency, plus write log.
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            we_q.push_back({mem_addr, mem_wdata});
        end
        mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        RESET = 1'b1; dn_download = 1'b0; dn_wr = 1'b0; dn_addr = '0; dn_data = '0;
        rd_req = 1'b0; rd_addr = '0;
        step(); step();
        check("rst_core_reset", core_reset, 1);
        check("rst_loaded", loaded, 0);
        check("rst_dropped", dropped, 0);
        check("rst_rd_ack", rd_ack, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_rd_data", rd_data, 0);
        RESET = 1'b0;
        step();

        // Download four bytes, three cycles apart
        dn_download = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dn_wr = 1'b1; dn_addr = 16'(i); dn_data = 8'(32'hA0 + i);
            step();
            dn_wr = 1'b0;
            step(); step();
        end
        check("dl_we_count", we_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("dl_we_%0d", i), we_q[i], {16'(i), 8'(32'hA0 + i)});
        end
        check("dl_core_reset", core_reset, 1);
        check("dl_dropped", dropped, 0);

        // Out-of-range address is dropped
        dn_wr = 1'b1; dn_addr = 16'hC000; dn_data = 8'hEE;
        step();
        dn_wr = 1'b0;
        step(); step(); step();
        check("oor_dropped", dropped, 1);
        check("oor_we_count", we_q.size(), 4);
        check("load_loaded", loaded, 0);

        // Download end: hold for HOLD cycles, then run
        dn_download = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (core_reset && n < 200);
        check("hold_edges", n, HOLD + 1);
        check("run_loaded", loaded, 1);

        // Back-to-back reads in RUN
        rd_req = 1'b1; rd_addr = 16'h0002;
        step();
        check("rd1_mem_addr", mem_addr, 16'h0002);
        check("rd1_mem_we", mem_we, 0);
        check("rd1_no_ack", rd_ack, 0);
        step();
        check("rd1_ack", rd_ack, 1);
        check("rd1_data", rd_data, 8'hA2);
        rd_addr = 16'h0003;
        step();
        check("rd2_no_ack", rd_ack, 0);
        check("rd2_mem_addr", mem_addr, 16'h0003);
        step();
        check("rd2_ack", rd_ack, 1);
        check("rd2_data", rd_data, 8'hA3);
        rd_req = 1'b0;
        step();
        check("rd_idle_ack", rd_ack, 0);
        check("run_core_reset", core_reset, 0);

        // Read and write in the same cycle, then an overrun
        dn_download = 1'b1;
        rd_req = 1'b1; rd_addr = 16'h0001;
        dn_wr = 1'b1; dn_addr = 16'h0010; dn_data = 8'h55;
        step();
        dn_addr = 16'h0011; dn_data = 8'h66;
        check("ov_mem_addr_rd", mem_addr, 16'h0001);
        check("ov_core_reset", core_reset, 1);
        step();
        dn_wr = 1'b0; rd_req = 1'b0;
        check("ov_rd_ack", rd_ack, 1);
        check("ov_rd_data", rd_data, 8'hA1);
        check("ov_we_blocked", mem_we, 0);
        check("ov_dropped", dropped, 2);
        step();
        check("ov_we", mem_we, 1);
        check("ov_we_addr", mem_addr, 16'h0010);
        check("ov_we_data", mem_wdata, 8'h55);
        step();
        check("ov_we_pulse", mem_we, 0);
        step();
        check("ov_we_count", we_q.size(), 5);

        // New byte in the drain cycle is accepted
        dn_wr = 1'b1; dn_addr = 16'h0020; dn_data = 8'h11;
        step();
        dn_addr = 16'h0021; dn_data = 8'h22;
        step();
        dn_wr = 1'b0;
        step(); step(); step();
        check("drain_we_count", we_q.size(), 7);
        check("drain_we_5", we_q[5], {16'h0020, 8'h11});
        check("drain_we_6", we_q[6], {16'h0021, 8'h22});
        check("drain_dropped", dropped, 2);

        // Reset during HOLD with a write still pending
        rd_req = 1'b1; rd_addr = 16'h0000;
        dn_wr = 1'b1; dn_addr = 16'h0030; dn_data = 8'h77;
        step();
        dn_wr = 1'b0; dn_download = 1'b0;
        check("rh_mem_addr_rd", mem_addr, 16'h0000);
        step();
        check("rh_rd_ack", rd_ack, 1);
        check("rh_rd_data", rd_data, 8'hA0);
        check("rh_we_pending", mem_we, 0);
        rd_req = 1'b0; RESET = 1'b1;
        step();
        RESET = 1'b0;
        check("rh_mem_we", mem_we, 0);
        check("rh_core_reset", core_reset, 1);
        check("rh_loaded", loaded, 0);
        check("rh_dropped", dropped, 0);
        check("rh_rd_ack_clr", rd_ack, 0);
        we_before = we_q.size();
        for (int i = 0; i < int'(HOLD) + 8; i++) step();
        check("rh_no_write", we_q.size(), we_before);
        check("rh_stays_boot", core_reset, 1);
        check("rh_loaded_late", loaded, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
